// File: rtl/aes_keysched_ctrl.sv
// rtl/aes_keysched_ctrl.sv - AES key-schedule sequencer between a round-key generator and a key consumer
module aes_keysched_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key_in,
    input  logic         abort,
    input  logic [127:0] gen_round_key,
    output logic [1:0]   gen_mode,
    output logic [255:0] gen_key,
    output logic [3:0]   gen_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] nr;

    // Last round index for the latched key size; the illegal code never gets latched.
    always_comb begin
        nr = 4'd10;
        case (gen_mode)
            2'b00:   nr = 4'd10;
            2'b01:   nr = 4'd12;
            2'b10:   nr = 4'd14;
            default: nr = 4'd10;
        endcase
    end

    // Run sequencer: latch, let the generator settle, present each key, then pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gen_mode  <= 2'b00;
            gen_key   <= '0;
            gen_round <= 4'd0;
            rk_valid  <= 1'b0;
            round_key <= '0;
            rk_index  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                    if (start) begin
                        if (mode == 2'b11) begin
                            err <= 1'b1;
                        end else begin
                            gen_mode  <= mode;
                            gen_key   <= key_in;
                            gen_round <= 4'd0;
                            busy      <= 1'b1;
                            state     <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        // The generator has had a full cycle on gen_round; take its result.
                        round_key <= gen_round_key;
                        rk_index  <= gen_round;
                        rk_valid  <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (abort) begin
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (gen_round >= nr) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            gen_round <= gen_round + 4'd1;
                            state     <= SETTLE;
                        end
                    end
                end
                FINISH: begin
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_keysched_ctrl.sv
// tb/tb_aes_keysched_ctrl.sv - directed self-checking bench for aes_keysched_ctrl
module tb_aes_keysched_ctrl;

    localparam logic [255:0] K128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] K192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         abort;
    logic [127:0] gen_round_key;
    logic [1:0]   gen_mode;
    logic [255:0] gen_key;
    logic [3:0]   gen_round;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Round-key generator stand-in: FIPS-197 schedule for the AES-128 example key,
    // raw key halves for AES-256 rounds 0/1, otherwise a round-tagged pattern.
    function automatic logic [127:0] exp_key(input logic [1:0] m, input logic [255:0] k, input logic [3:0] r);
        if (m == 2'b00 && k == K128) begin
            case (r)
                4'd0:    return 128'h2b7e151628aed2a6abf7158809cf4f3c;
                4'd1:    return 128'ha0fafe1788542cb123a339392a6c7605;
                4'd2:    return 128'hf2c295f27a96b9435935807a7359f67f;
                4'd3:    return 128'h3d80477d4716fe3e1e237e446d7a883b;
                4'd4:    return 128'hef44a541a8525b7fb671253bdb0bad00;
                4'd5:    return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
                4'd6:    return 128'h6d88a37a110b3efddbf98641ca0093fd;
                4'd7:    return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
                4'd8:    return 128'head27321b58dbad2312bf5607f8d292f;
                4'd9:    return 128'hac7766f319fadc2128d12941575c006e;
                4'd10:   return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
                default: return 128'h0;
            endcase
        end else if (m == 2'b10 && r == 4'd0) begin
            return k[255:128];
        end else if (m == 2'b10 && r == 4'd1) begin
            return k[127:0];
        end
        return k[127:0] ^ {32{r}};
    endfunction

    assign gen_round_key = exp_key(gen_mode, gen_key, gen_round);

    aes_keysched_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .key_in        (key_in),
        .abort         (abort),
        .gen_round_key (gen_round_key),
        .gen_mode      (gen_mode),
        .gen_key       (gen_key),
        .gen_round     (gen_round),
        .rk_valid      (rk_valid),
        .rk_ready      (rk_ready),
        .round_key     (round_key),
        .rk_index      (rk_index),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run; cycle 1 is the start edge. Optionally holds rk_ready low stall_n cycles on key stall_idx.
    task automatic run(input logic [1:0] m, input logic [255:0] k, input int stall_idx, input int stall_n,
                       output int nkeys, output int done_cyc, output int first_cyc, output logic [127:0] last_key);
        int           cyc;
        int           stalled;
        bit           fin;
        logic [127:0] snap_key;
        logic [3:0]   snap_idx;
        nkeys = 0; done_cyc = -1; first_cyc = -1; last_key = '0;
        stalled = 0; fin = 1'b0; snap_key = '0; snap_idx = '0;
        mode = m; key_in = k; start = 1'b1; rk_ready = 1'b1;
        tick();
        cyc = 1;
        start = 1'b0;
        check("latch_mode", gen_mode, m);
        check("latch_key", gen_key, k);
        check("first_round", gen_round, 0);
        check("busy_run", busy, 1);
        while (!fin && cyc < 200) begin
            tick();
            cyc++;
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
                check("done_no_valid", rk_valid, 0);
            end else if (rk_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (int'(rk_index) == stall_idx && stalled < stall_n) begin
                    if (stalled == 0) begin
                        snap_key = round_key;
                        snap_idx = rk_index;
                    end else begin
                        check("stall_key", round_key, snap_key);
                        check("stall_idx", rk_index, snap_idx);
                    end
                    stalled++;
                    rk_ready = 1'b0;
                end else begin
                    if (stalled > 0 && int'(rk_index) == stall_idx) begin
                        check("stall_key_last", round_key, snap_key);
                    end
                    check("rk_index", rk_index, nkeys);
                    check("round_key", round_key, exp_key(m, k, nkeys[3:0]));
                    last_key = round_key;
                    nkeys++;
                    rk_ready = 1'b1;
                end
            end
        end
        rk_ready = 1'b1;
        if (!fin) check("run_timeout", 0, 1);
        tick();
        check("idle_after_done", {busy, done, rk_valid}, 0);
    endtask

    initial begin
        int           nk;
        int           dc;
        int           fc;
        bit           found;
        logic [127:0] lk;

        rst = 1'b1; start = 1'b0; mode = 2'b00; key_in = '0; abort = 1'b0; rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {gen_mode, gen_round, rk_valid, rk_index, busy, done, err}, 0);
        check("rst_gen_key", gen_key, 0);
        check("rst_round_key", round_key, 0);
        rst = 1'b0;
        tick();

        // Illegal mode: error pulse, nothing latched, stays idle.
        mode = 2'b11; key_in = K256; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_valid", rk_valid, 0);
        check("err_no_latch", gen_key, 0);
        tick();
        check("err_one_cycle", {err, busy, rk_valid}, 0);

        run(2'b00, K128, -1, 0, nk, dc, fc, lk);
        check("aes128_keys", nk, 11);
        check("aes128_first", fc, 2);
        check("aes128_done", dc, 23);
        check("aes128_key10", lk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(2'b10, K256, -1, 0, nk, dc, fc, lk);
        check("aes256_keys", nk, 15);
        check("aes256_done", dc, 31);

        run(2'b01, K192, 3, 5, nk, dc, fc, lk);
        check("aes192_keys", nk, 13);
        check("aes192_done", dc, 32);

        // Abort while key 4 is presented and accepted in the same cycle.
        mode = 2'b00; key_in = K128; start = 1'b1; rk_ready = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (rk_valid && rk_index == 4'd4) found = 1'b1;
        end
        check("abort_reach", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {busy, rk_valid, done}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_quiet", {busy, rk_valid, done}, 0);
        end

        // Start with abort in idle: run begins, from round 0.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_round", gen_round, 0);
        tick();
        check("restart_valid", rk_valid, 1);
        check("restart_index", rk_index, 0);
        check("restart_key", round_key, K128[127:0]);

        // Start while busy is ignored.
        tick();
        mode = 2'b10; key_in = K256; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_mode", gen_mode, 2'b00);
        check("busy_start_key", gen_key, K128);
        check("busy_start_run", {rk_valid, rk_index}, {1'b1, 4'd1});

        // Reset between edges mid-run: outputs clear without waiting for a clock.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", {gen_mode, gen_round, rk_valid, rk_index, busy, done, err}, 0);
        check("async_rst_key", {gen_key, round_key}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", {busy, rk_valid, done}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_keysched_ctrl.md
AES_KEYSCHED_CTRL -- requirements
Module: aes_keysched_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a key-schedule run; sampled in IDLE only.
REQ-005 mode  input  2  00 AES-128, 01 AES-192, 10 AES-256, 11 illegal.
REQ-006 key_in  input  256  cipher key; AES-128/192 use [127:0] / [191:0], AES-256 uses all bits.
REQ-007 abort  input  1  synchronous run cancel.
REQ-008 gen_round_key  input  128  round key returned by the round-key generator for gen_round.
REQ-009 gen_mode  output  2  latched mode, driven to the generator.
REQ-010 gen_key  output  256  latched key, driven to the generator.
REQ-011 gen_round  output  4  round index driven to the generator.
REQ-012 rk_valid  output  1  round_key and rk_index hold a valid key.
REQ-013 rk_ready  input  1  consumer accepts the key when rk_valid and rk_ready are both high.
REQ-014 round_key  output  128  registered round key.
REQ-015 rk_index  output  4  round number of round_key.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse after the final key is accepted.
REQ-018 err  output  1  one-cycle pulse when start is issued with mode=11.

Function
REQ-019 Nr SHALL be 10, 12 or 14 for mode 00, 01 or 10; one run SHALL emit Nr+1 keys, for rounds 0..Nr in ascending order.
REQ-020 FSM states SHALL be IDLE, SETTLE, PRESENT and FINISH.
REQ-021 IDLE, start=1, mode!=11: latch mode and key_in into gen_mode and gen_key, set gen_round=0, next state SETTLE.
REQ-022 IDLE, start=1, mode=11: err=1 for one cycle, no latch, stay in IDLE.
REQ-023 SETTLE SHALL last exactly one cycle, giving the generator a one-cycle register delay.
REQ-024 On leaving SETTLE, the block SHALL capture round_key<=gen_round_key and rk_index<=gen_round, and move to PRESENT.
REQ-025 PRESENT SHALL hold rk_valid=1, with round_key and rk_index stable, until rk_ready=1.
REQ-026 On acceptance with gen_round<Nr: gen_round SHALL increment by 1, rk_valid SHALL be 0 the next cycle, next state SETTLE.
REQ-027 On acceptance with gen_round=Nr: next state FINISH.
REQ-028 FINISH SHALL assert done=1 for one cycle, then go to IDLE.
REQ-029 Latency: first rk_valid SHALL occur 2 cycles after the start edge.
REQ-030 Throughput: with rk_ready held high, one key every 2 cycles.
REQ-031 Total run length with rk_ready held high: 2(Nr+1)+1 cycles from the start edge to done.
REQ-032 gen_round SHALL never exceed Nr and SHALL never wrap.
REQ-033 start SHALL be ignored while busy=1; latched mode and key SHALL NOT change during a run.
REQ-034 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with rk_valid=0 and no done pulse.
REQ-035 abort SHALL take priority over rk_ready acceptance in the same cycle.
REQ-036 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL start a run (abort ignored).
REQ-037 done and err SHALL never be high together; rk_valid SHALL be 0 in IDLE, SETTLE and FINISH.

Reset
REQ-038 rst=1 SHALL immediately force state=IDLE and all outputs to 0: gen_mode, gen_key, gen_round, rk_valid, round_key, rk_index, busy, done, err.
REQ-039 rst asserted mid-run SHALL discard the run; after release, no key SHALL be emitted until a new start.

Verification
REQ-040 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> 11 keys, index 0..10; key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done at cycle 23.
REQ-041 AES-256, FIPS-197 key 603deb10...0914dff4, rk_ready=1 -> 15 keys; key 0 = key_in[255:128], key 1 = key_in[127:0]; done at cycle 31.
REQ-042 AES-192 with rk_ready low 5 cycles on key 3 -> rk_valid, round_key and rk_index stable all 5 cycles; 13 keys total, none duplicated or skipped.
REQ-043 mode=11 start -> err pulse 1 cycle, busy stays 0, no rk_valid.
REQ-044 abort during PRESENT of key 4, same cycle as rk_ready=1 -> IDLE next cycle, no done; a new start then begins again at index 0.
REQ-045 rst asserted between clock edges mid-run -> outputs 0 immediately; start pulse while busy -> ignored, current run unchanged.
